scratch_wr_arbiter: RTL and testbench
=====================================

# scratch_wr_arbiter

Two-client write-port arbiter for the scratch memory. It buffers 128-bit write requests from two datapath engines and serializes them onto the single scratch memory write port, one write per cycle. Client 0 is the row-pass engine and client 1 is the column-pass engine. The block sits between those engines and the scratch memory `WE`/`WriteAddress`/`WriteBus` port inside `top_without_mem`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per client FIFO. Must be a power of 2 and ≥ 2.
- `AW`, default 16: address width.
- `DW`, default 128: data width.

Ports:
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `c0_wr_valid`  input  1  client 0 write request.
- `c0_wr_ready`  output  1  client 0 FIFO can accept.
- `c0_wr_addr`  input  AW  client 0 write address.
- `c0_wr_data`  input  DW  client 0 write data.
- `c1_wr_valid`, `c1_wr_ready`, `c1_wr_addr`, `c1_wr_data`: same as client 0, for client 1.
- `scratch_mem_WE`  output  1  registered write enable to scratch memory.
- `scratch_mem_waddr`  output  AW  registered write address.
- `scratch_mem_wdata`  output  DW  registered write data.
- `idle`  output  1  high when both FIFOs are empty and `scratch_mem_WE` is 0.

## Operation
- **Per-client FIFO.** Each client has its own FIFO holding {addr, data}, `FIFO_DEPTH` entries.
  - A push happens on a clock edge where `cN_wr_valid & cN_wr_ready`.
  - `cN_wr_ready` = FIFO not full. It is a registered/combinational function of the count only and does not depend on `cN_wr_valid`.
  - A full FIFO deasserts ready even if a pop is in progress in the same cycle; there is no pass-through credit.
- **Arbiter.** Each cycle it selects at most one non-empty FIFO, pops its head, and loads the output registers.
  - Exactly one FIFO non-empty: that FIFO is selected.
  - Both non-empty: round-robin via a 1-bit priority pointer `rr`. The client equal to `rr` wins. After any grant, `rr` becomes the other client (~granted).
  - Both empty: `scratch_mem_WE` is 0 next cycle; `scratch_mem_waddr` and `scratch_mem_wdata` hold their last values.
- **Simultaneous push and pop on the same FIFO.** Both occur. The count is unchanged and ordering is preserved. A push into an empty FIFO is not poppable until the following cycle.
- **Ordering and addresses.**
  - Per-client FIFO order is preserved.
  - There is no ordering guarantee between clients. Engines must not write the same address concurrently.
  - There is no address checking.
- **Pointer and count widths.**
  - Read/write pointers are log2(`FIFO_DEPTH`) bits and wrap naturally from `FIFO_DEPTH`-1 to 0.
  - The count is log2(`FIFO_DEPTH`)+1 bits, so a full FIFO reads as count = `FIFO_DEPTH`.
- **Reset (asynchronous assert, synchronous release).**
  - Both FIFOs empty and all pointers 0.
  - `rr` = 0 (client 0 priority).
  - `scratch_mem_WE` = 0, `scratch_mem_waddr` = 0, `scratch_mem_wdata` = 0.
  - `c0_wr_ready` and `c1_wr_ready` are forced to 0 while `reset` is low, and are 1 from the first cycle after release.
  - `idle` = 1.
- **Reset mid-operation.** All buffered writes are discarded and no further `WE` pulses are issued. A write already on the output registers in the reset cycle is cleared.

## Timing
- **Latency.** A request accepted at edge N (FIFO previously empty, no contention) appears as `scratch_mem_WE`=1 with its addr/data during the cycle after edge N+1. That is 2 cycles from handshake to `WE`.
- **Throughput.**
  - Aggregate: one write per cycle.
  - Under continuous contention, each client gets one write every 2 cycles, strictly alternating.
  - A single active client sustains 1 write/cycle once its FIFO holds ≥ 1 entry.
- **`WE` pulse width.** `scratch_mem_WE` is high for exactly one cycle per popped entry. Back-to-back pops give back-to-back high cycles.
- **`idle`.**
  - Combinational from FIFO-empty flags and the `WE` register.
  - Goes high the cycle after the last write pulse.
  - The controller uses it as the pass-complete condition.

## Configuration
- Macro: `SCRATCH_WR_ARB_FIXED_PRIO_EN`.
- **Defined:** client 0 always wins when both FIFOs are non-empty. The `rr` register is not implemented. Client 1 is served only when FIFO 0 is empty.
- **Undefined (default):** round-robin as described above.
- Latency, reset values and FIFO behaviour are identical in both builds.

## Test plan
- **Reset:** release `reset` with no traffic → `WE`=0, `waddr`=0, `wdata`=0, `idle`=1, both readies = 1 one cycle after release.
- **Single write:** client 0 writes addr 0x0010, data 0xA5…A5 at edge N → `WE`=1, `waddr`=0x0010 in cycle after N+1 only. `idle` returns to 1 one cycle later.
- **Contention (round-robin build):** both clients hold valid continuously with addrs 0x100+i and 0x200+i → `waddr` sequence 0x100, 0x200, 0x101, 0x201, …, with `WE` high every cycle. Under `SCRATCH_WR_ARB_FIXED_PRIO_EN`, client 0 is served first: no client-1 grant occurs until FIFO 0 drains.
- **Full and wrap-around:** `FIFO_DEPTH`=4, client 1 pushes 4 entries while client 0 streams continuously (fixed-priority build) → `c1_wr_ready`=0 after the 4th push. When client 0 stops, all 4 client-1 entries are drained in order, and 6 further pushes wrap the pointers with data intact.
- **Reset mid-stream:** assert `reset` with 3 entries buffered and `WE`=1 → `WE`=0 immediately (asynchronous). After release, no stale writes appear and `idle`=1.
- **Simultaneous push and pop:** client 0 streams at 1/cycle for 20 cycles → `c0_wr_ready` stays 1 throughout, the count never exceeds 1, and there are 20 consecutive `WE` pulses in order.

Source files
------------

// File: rtl/scratch_wr_arbiter_if.sv
// Write-request and scratch-memory write-port bundle for scratch_wr_arbiter.
// The arbiter takes the slave modport; the engines/memory side takes master.
interface scratch_wr_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 128
);
  logic          c0_wr_valid;
  logic          c0_wr_ready;
  logic [AW-1:0] c0_wr_addr;
  logic [DW-1:0] c0_wr_data;
  logic          c1_wr_valid;
  logic          c1_wr_ready;
  logic [AW-1:0] c1_wr_addr;
  logic [DW-1:0] c1_wr_data;
  logic          scratch_mem_WE;
  logic [AW-1:0] scratch_mem_waddr;
  logic [DW-1:0] scratch_mem_wdata;
  logic          idle;

  modport master (
    output c0_wr_valid, c0_wr_addr, c0_wr_data,
    output c1_wr_valid, c1_wr_addr, c1_wr_data,
    input  c0_wr_ready, c1_wr_ready,
    input  scratch_mem_WE, scratch_mem_waddr, scratch_mem_wdata, idle
  );

  modport slave (
    input  c0_wr_valid, c0_wr_addr, c0_wr_data,
    input  c1_wr_valid, c1_wr_addr, c1_wr_data,
    output c0_wr_ready, c1_wr_ready,
    output scratch_mem_WE, scratch_mem_waddr, scratch_mem_wdata, idle
  );
endinterface

// File: rtl/scratch_wr_arbiter.sv
// Two-client scratch-memory write arbiter: per-client FIFOs serialised onto one registered
// write port. Define SCRATCH_WR_ARB_FIXED_PRIO_EN for fixed client-0 priority (default RR).
module scratch_wr_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 128
) (
  input logic                 clock,
  input logic                 reset,
  scratch_wr_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = AW + DW;
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

  logic [EW-1:0] mem_q  [2][FIFO_DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] rptr_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic [EW-1:0] wentry [2];
  logic [EW-1:0] head;

  logic [1:0] valid;
  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] nempty;
  logic [1:0] gnt;

  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  always_comb begin
    valid     = {bus.c1_wr_valid, bus.c0_wr_valid};
    wentry[0] = {bus.c0_wr_addr, bus.c0_wr_data};
    wentry[1] = {bus.c1_wr_addr, bus.c1_wr_data};
    nempty    = '0;
    ready     = '0;
    for (int i = 0; i < 2; i++) begin
      nempty[i] = (cnt_q[i] != '0);
      // Ready is a function of count only; held low while reset is asserted.
      ready[i]  = reset & (cnt_q[i] != CntFull);
    end
    push = valid & ready;
  end

`ifdef SCRATCH_WR_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt[0] = nempty[0];
    gnt[1] = nempty[1] & ~nempty[0];
  end
`else
  logic rr_q;

  always_comb begin
    gnt[0] = nempty[0] & (~nempty[1] | ~rr_q);
    gnt[1] = nempty[1] & (~nempty[0] | rr_q);
  end

  // After a grant the other client gets priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (|gnt) begin
      rr_q <= gnt[0];
    end
  end
`endif

  assign head = gnt[1] ? mem_q[1][rptr_q[1]] : mem_q[0][rptr_q[0]];

  // Storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= wentry[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wptr_q[i] <= wptr_q[i] + 1'b1;
        end
        if (gnt[i]) begin
          rptr_q[i] <= rptr_q[i] + 1'b1;
        end
        if (push[i] && !gnt[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (!push[i] && gnt[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
      we_q <= |gnt;
      if (|gnt) begin
        {waddr_q, wdata_q} <= head;
      end
    end
  end

  assign bus.c0_wr_ready       = ready[0];
  assign bus.c1_wr_ready       = ready[1];
  assign bus.scratch_mem_WE    = we_q;
  assign bus.scratch_mem_waddr = waddr_q;
  assign bus.scratch_mem_wdata = wdata_q;
  assign bus.idle              = ~|nempty & ~we_q;

endmodule

// File: tb/tb_scratch_wr_arbiter.sv
// Scoreboard bench for scratch_wr_arbiter: a queue-based reference model predicts every write,
// a negedge monitor pops and compares. Honours SCRATCH_WR_ARB_FIXED_PRIO_EN.
module tb_scratch_wr_arbiter;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;
`ifdef SCRATCH_WR_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  typedef logic [AW+DW-1:0] ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  scratch_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  scratch_wr_arbiter #(
    .FIFO_DEPTH(D),
    .AW        (AW),
    .DW        (DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference model: two bounded queues, a priority bit, and a queue of predicted writes.
  ent_t m0[$];
  ent_t m1[$];
  ent_t sb[$];
  bit   rr     = 1'b0;
  bit   exp_we = 1'b0;
  bit   p0, p1;
  int   g;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m0.delete();
      m1.delete();
      sb.delete();
      rr     = 1'b0;
      exp_we = 1'b0;
    end else begin
      p0 = bus.c0_wr_valid && (m0.size() < D);
      p1 = bus.c1_wr_valid && (m1.size() < D);
      g  = -1;
      if (m0.size() != 0 && m1.size() != 0) g = FixedPrio ? 0 : int'(rr);
      else if (m0.size() != 0) g = 0;
      else if (m1.size() != 0) g = 1;
      exp_we = (g >= 0);
      if (g == 0) sb.push_back(m0.pop_front());
      else if (g == 1) sb.push_back(m1.pop_front());
      if (g >= 0) rr = (g == 0);
      if (p0) m0.push_back({bus.c0_wr_addr, bus.c0_wr_data});
      if (p1) m1.push_back({bus.c1_wr_addr, bus.c1_wr_data});
    end
  end

  // Monitor
  ent_t          got;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  always @(negedge clock) begin
    if (!reset) begin
      last_a = '0;
      last_d = '0;
    end
    chk("we", bus.scratch_mem_WE, exp_we);
    if (bus.scratch_mem_WE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", bus.scratch_mem_waddr);
      end else begin
        got    = sb.pop_front();
        last_a = got[AW+DW-1:DW];
        last_d = got[DW-1:0];
      end
    end
    chk("waddr", bus.scratch_mem_waddr, last_a);
    chk("wdata", bus.scratch_mem_wdata, last_d);
    chk("rdy0", bus.c0_wr_ready, reset && (m0.size() < D));
    chk("rdy1", bus.c1_wr_ready, reset && (m1.size() < D));
    chk("idle", bus.idle, (m0.size() == 0) && (m1.size() == 0) && !exp_we);
  end

  task automatic idle_inputs();
    bus.c0_wr_valid = 1'b0;
    bus.c1_wr_valid = 1'b0;
  endtask

  // Ordered streams: the address advances only when the previous request was accepted.
  task automatic stream(input int cycles, input bit en0, input bit en1,
                        input logic [AW-1:0] b0, input logic [AW-1:0] b1);
    int i0 = 0;
    int i1 = 0;
    bit a0 = 1'b0;
    bit a1 = 1'b0;
    repeat (cycles) begin
      @(negedge clock);
      if (a0) i0++;
      if (a1) i1++;
      bus.c0_wr_valid = en0;
      bus.c0_wr_addr  = b0 + AW'(i0);
      bus.c0_wr_data  = rnd();
      bus.c1_wr_valid = en1;
      bus.c1_wr_addr  = b1 + AW'(i1);
      bus.c1_wr_data  = rnd();
      a0 = en0 && bus.c0_wr_ready;
      a1 = en1 && bus.c1_wr_ready;
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!bus.idle && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk(name, (n < 100), 1'b1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    idle_inputs();
    bus.c0_wr_addr = '0;
    bus.c0_wr_data = '0;
    bus.c1_wr_addr = '0;
    bus.c1_wr_data = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    repeat (3) @(negedge clock);

    // Single write with the A5 pattern
    @(negedge clock);
    bus.c0_wr_valid = 1'b1;
    bus.c0_wr_addr  = 16'h0010;
    bus.c0_wr_data  = {16{8'hA5}};
    @(negedge clock);
    idle_inputs();
    chk("single_lat1_we", bus.scratch_mem_WE, 1'b0);
    @(negedge clock);
    chk("single_lat2_we", bus.scratch_mem_WE, 1'b1);
    chk("single_addr", bus.scratch_mem_waddr, 16'h0010);
    @(negedge clock);
    chk("single_idle_after", bus.idle, 1'b1);
    drain("single_drain");

    // Sustained contention; also fills both FIFOs
    stream(30, 1'b1, 1'b1, 16'h0100, 16'h0200);
    drain("contention_drain");

    // Client 1 fills while client 0 streams, then client 1 alone wraps pointers
    stream(12, 1'b1, 1'b1, 16'h0500, 16'h0600);
    stream(10, 1'b0, 1'b1, 16'h0000, 16'h0700);
    drain("wrap_drain");

    // Reset in the middle of a busy stream
    fork
      stream(20, 1'b1, 1'b1, 16'h0300, 16'h0400);
      begin
        repeat (8) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_we", bus.scratch_mem_WE, 1'b0);
        chk("midrst_idle", bus.idle, 1'b1);
        chk("midrst_rdy0", bus.c0_wr_ready, 1'b0);
        @(posedge clock);
        #2 reset = 1'b1;
      end
    join
    drain("midrst_drain");

    // Single client at one write per cycle
    stream(20, 1'b1, 1'b0, 16'h0800, 16'h0000);
    drain("stream_drain");

    // Random traffic
    repeat (300) begin
      @(negedge clock);
      bus.c0_wr_valid = ($urandom_range(0, 9) < 6);
      bus.c0_wr_addr  = AW'($urandom());
      bus.c0_wr_data  = rnd();
      bus.c1_wr_valid = ($urandom_range(0, 9) < 6);
      bus.c1_wr_addr  = AW'($urandom());
      bus.c1_wr_data  = rnd();
    end
    @(negedge clock);
    idle_inputs();
    drain("random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
